// File: rtl/lab_pkg.sv
// Shared constants and helpers for the lab designs: default widths and the
// width of a counter that must hold the value PAT_W.
package lab_pkg;

  localparam int PAT_W_DEF = 6;
  localparam int CNT_W_DEF = 4;

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronises an asynchronous push-button level into clk and turns each
// rising edge of it into a single registered one-cycle enable strobe.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic in_pulse,
  output logic clk_en
);

  logic s1;
  logic s2;
  logic s3;

  // s1 may go metastable; only s2 and later are used as logic inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      clk_en <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the
      // pre-edge value of its neighbour, which is what forms the chain.
      s1     <= in_pulse;
      s2     <= s1;
      s3     <= s2;
      clk_en <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/serial_pattern_counter.sv
// Serial pattern detector with match counter: each step strobe shifts one
// bit into a PAT_W window, compares it to a runtime pattern and counts hits.
module serial_pattern_counter
  import lab_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic             ser_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             clk_en,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             match,
  output logic [CNT_W-1:0] cnt_out
);

  localparam int               FW      = fill_w(PAT_W);
  localparam logic [FW-1:0]    FULL    = FW'(PAT_W);
  localparam logic [FW-1:0]    ONE     = FW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] window_next;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic [FW-1:0]    arm;
  logic [FW-1:0]    arm_next;
  logic [CNT_W-1:0] cnt_next;
  logic             hit;

  pulse_sync_edge u_step (
    .clk      (clk),
    .rst      (rst),
    .in_pulse (in_pulse),
    .clk_en   (clk_en)
  );

  // The match is judged on the window as it will be after this shift, so
  // match and cnt_out change on the same edge that consumes the bit.
  always_comb begin
    window_next = {window[PAT_W-2:0], ser_in};
    fill_next   = (fill == FULL) ? fill : fill + ONE;
    arm_next    = (arm  == FULL) ? arm  : arm  + ONE;
    hit         = clk_en && (arm_next == FULL) && (window_next == pattern);
    if (SAT && (cnt_out == CNT_MAX)) cnt_next = cnt_out;
    else                             cnt_next = cnt_out + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window  <= '0;
      fill    <= '0;
      arm     <= '0;
      match   <= 1'b0;
      cnt_out <= '0;
    end else if (clear) begin
      // clear outranks a coincident step; that bit is dropped on purpose.
      window  <= '0;
      fill    <= '0;
      arm     <= '0;
      match   <= 1'b0;
      cnt_out <= '0;
    end else begin
      match <= hit;
      if (clk_en) begin
        window <= window_next;
        fill   <= fill_next;
        // Non-overlapping mode re-arms; the delay line itself keeps running.
        arm    <= (hit && !overlap) ? '0 : arm_next;
        if (hit) cnt_out <= cnt_next;
      end
    end
  end

  assign ser_out       = window[PAT_W-1];
  assign ser_out_valid = (fill == FULL);

endmodule

// File: tb/tb_serial_pattern_counter.sv
// Scoreboard bench: stimulus pushes expected post-step outputs from a queue
// model; a monitor pops one entry after every observed clk_en strobe.
module tb_serial_pattern_counter;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_pulse = 1'b0;
  logic          ser_in = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic          overlap = 1'b0;
  logic          clear = 1'b0;

  logic          clk_en0, ser_out0, valid0, match0;
  logic [3:0]    cnt0;
  logic          clk_en1, ser_out1, valid1, match1;
  logic [1:0]    cnt1;

  serial_pattern_counter #(.PAT_W(PW), .CNT_W(4), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_pulse(in_pulse), .ser_in(ser_in),
    .pattern(pattern), .overlap(overlap), .clear(clear),
    .clk_en(clk_en0), .ser_out(ser_out0), .ser_out_valid(valid0),
    .match(match0), .cnt_out(cnt0)
  );

  serial_pattern_counter #(.PAT_W(PW), .CNT_W(2), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_pulse(in_pulse), .ser_in(ser_in),
    .pattern(pattern), .overlap(overlap), .clear(clear),
    .clk_en(clk_en1), .ser_out(ser_out1), .ser_out_valid(valid1),
    .match(match1), .cnt_out(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       match;
    logic [3:0] cnt0;
    logic [1:0] cnt1;
    logic       ser_out;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  bit   bits_q[$];
  int   since_arm = 0;
  int   total = 0;
  int   checks = 0;
  int   failures = 0;
  int   en_count = 0;
  int   steps_issued = 0;
  bit   en_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: remember only the last PW bits received and how many
  // bits have arrived since the detector was last (re)armed.
  function automatic logic [PW-1:0] model_window();
    logic [PW-1:0] w;
    int n;
    w = '0;
    n = bits_q.size();
    for (int i = 0; i < PW; i++) begin
      int idx;
      idx = n - PW + i;
      w = {w[PW-2:0], (idx >= 0) ? bits_q[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_clear();
    bits_q.delete();
    since_arm = 0;
    total = 0;
  endtask

  task automatic model_step(input bit b, input bit clr);
    exp_t e;
    bit   hit;
    e = '0;
    if (clr) begin
      model_clear();
    end else begin
      bits_q.push_back(b);
      if (bits_q.size() > PW) void'(bits_q.pop_front());
      if (since_arm < PW) since_arm++;
      hit = (since_arm == PW) && (model_window() == pattern);
      if (hit) begin
        total++;
        if (!overlap) since_arm = 0;
      end
      e.match   = hit;
      e.cnt0    = 4'(total % 16);
      e.cnt1    = (total > 3) ? 2'd3 : 2'(total);
      e.valid   = (bits_q.size() == PW);
      e.ser_out = e.valid ? bits_q[0] : 1'b0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: the cycle after a clk_en strobe holds the result of that step.
  always @(negedge clk) begin
    if (!rst) begin
      en_prev = 1'b0;
    end else begin
      if (en_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("match0",   32'(match0),   32'(e.match));
          check("match1",   32'(match1),   32'(e.match));
          check("cnt_wrap", 32'(cnt0),     32'(e.cnt0));
          check("cnt_sat",  32'(cnt1),     32'(e.cnt1));
          check("ser_out0", 32'(ser_out0), 32'(e.ser_out));
          check("ser_out1", 32'(ser_out1), 32'(e.ser_out));
          check("valid0",   32'(valid0),   32'(e.valid));
          check("valid1",   32'(valid1),   32'(e.valid));
        end
      end else begin
        check("idle_match", 32'({match0, match1}), 32'(0));
      end
      en_prev = clk_en0;
      if (clk_en0) en_count++;
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 32'({clk_en0, ser_out0, valid0, match0, cnt0,
                     clk_en1, ser_out1, valid1, match1, cnt1}), 32'(0));
  endtask

  // One push-button step; in_pulse is raised at N0, clk_en must be seen
  // exactly at the third following negedge.
  task automatic step(input bit b, input bit clr, input int hold);
    int len;
    len = (hold > 4) ? hold : 4;
    @(negedge clk);
    in_pulse = 1'b1;
    ser_in   = b;
    model_step(b, clr);
    steps_issued++;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == hold) in_pulse = 1'b0;
      check("clk_en_timing", 32'({clk_en0, clk_en1}), (i == 3) ? 32'(3) : 32'(0));
      if (clr && i == 3) clear = 1'b1;
      if (i == 4) clear = 1'b0;
    end
    in_pulse = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear(input logic [PW-1:0] p, input bit o);
    @(negedge clk);
    pattern = p;
    overlap = o;
    clear   = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0;
    check("after_clear", 32'({valid0, cnt0, ser_out0, valid1, cnt1, match0}), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    model_clear();
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pos;
    bit b;

    pattern = 6'b110101;
    overlap = 1'b0;
    #50;
    check_all_zero("reset_state");
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");

    // Held-high in_pulse for 10 cycles gives exactly one strobe.
    step(1'b1, 1'b0, 10);
    send_bits(32'b10101, 5);

    do_clear(6'b101010, 1'b1);
    send_bits(32'b10101010, 8);
    check("overlap_cnt", 32'(cnt0), 32'(2));
    do_clear(6'b101010, 1'b0);
    send_bits(32'b10101010, 8);
    check("no_overlap_cnt", 32'(cnt0), 32'(1));

    // 25 zeros against an all-zero pattern: 20 overlapping matches.
    do_clear(6'b000000, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1);
    check("wrap_cnt", 32'(cnt0), 32'(4));
    check("sat_cnt",  32'(cnt1), 32'(3));

    // clear on the completing bit of a match discards it.
    do_clear(6'b110101, 1'b0);
    send_bits(32'b11010, 5);
    step(1'b1, 1'b1, 2);

    // Reset between shift 3 and shift 4, then a full pattern.
    send_bits(32'b110, 3);
    do_reset();
    send_bits(32'b110101, 6);
    check("after_reset_match_cnt", 32'(cnt0), 32'(1));

    pos = 0;
    for (int it = 0; it < 300; it++) begin
      bit clr;
      if (it % 40 == 0) begin
        do_clear(PW'($urandom), 1'($urandom_range(1)));
        pos = 0;
      end
      b   = ($urandom_range(3) != 0) ? pattern[PW-1-(pos % PW)] : 1'($urandom_range(1));
      clr = ($urandom_range(19) == 0);
      step(b, clr, $urandom_range(5, 1));
      pos = clr ? 0 : pos + 1;
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("clk_en_count",  32'(en_count),     32'(steps_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
